apb_rst_ctrl: RTL and testbench

//  Reset controller directly downstream of apb_watchdog. Consumes wdg_rst (and wdg_int

---
 rtl/apb_rst_ctrl.sv | 175 +++++++++++++++++
 tb/tb_apb_rst_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rst_ctrl.sv
// Reset controller: stretches watchdog/software reset requests into a synchronously
// released sys_rstn and keeps sticky reset-cause flags. Option macro: RSTC_WDG_IRQ_EN.
module apb_rst_ctrl #(
  parameter int unsigned RST_LEN_DEF = 200,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] SW_KEY      = 16'hA5C3
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        psel,
  input  logic        penable,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  input  logic        wdg_rst,
  input  logic        wdg_int,
  output logic        sys_rstn,
  output logic        irq
);

  typedef enum logic [1:0] {HOLD, SYNC, RUN} state_t;

  localparam logic [15:0] LEN_DEF = 16'(RST_LEN_DEF);
  localparam logic [15:0] CNT_POR = 16'(RST_LEN_DEF - 1);
  localparam logic [15:0] SYNC_LD = 16'(SYNC_STAGES - 1);

  function automatic logic [3:0] wcnt_sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [15:0] len_to_cnt(input logic [15:0] len);
    return (len == 16'd0) ? 16'd0 : len - 16'd1;
  endfunction

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        sys_rstn_q;
  logic [15:0] len_q;
  logic        porf_q, wdgf_q, swf_q;
  logic [3:0]  wcnt_q;

  logic        wr, rd, wr_rcr, wr_rsr;
  logic        sw_req, in_run, wdg_evt, sw_evt, trig;
  logic [15:0] len_new;
  logic [3:0]  wcnt_base;
  logic [31:0] rdata, isr_rdata;

  assign wr      = psel & pwrite;
  assign rd      = psel & ~pwrite;
  assign wr_rcr  = wr & (paddr[3:2] == 2'b00);
  assign wr_rsr  = wr & (paddr[3:2] == 2'b01);
  assign sw_req  = wr_rcr & (pwdata[31:16] == SW_KEY);
  assign in_run  = (state_q == RUN);
  assign wdg_evt = in_run & wdg_rst;
  assign sw_evt  = in_run & sw_req;
  assign trig    = wdg_evt | sw_evt;
  // A key write that also carries a new LEN must use that LEN for its own sequence.
  assign len_new = wr_rcr ? pwdata[15:0] : len_q;
  assign wcnt_base = (wr_rsr & pwdata[3]) ? 4'd0 : wcnt_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= HOLD;
      cnt_q      <= CNT_POR;
      sys_rstn_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (trig) begin
            state_q    <= HOLD;
            cnt_q      <= len_to_cnt(len_new);
            sys_rstn_q <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt_q == 16'd0) begin
            state_q <= SYNC;
            cnt_q   <= SYNC_LD;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        SYNC: begin
          if (cnt_q == 16'd0) begin
            state_q    <= RUN;
            sys_rstn_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: begin
          state_q    <= HOLD;
          cnt_q      <= CNT_POR;
          sys_rstn_q <= 1'b0;
        end
      endcase
    end
  end

  // Cause flags: set events take priority over write-one-to-clear on the same edge.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      len_q  <= LEN_DEF;
      porf_q <= 1'b1;
      wdgf_q <= 1'b0;
      swf_q  <= 1'b0;
      wcnt_q <= 4'd0;
    end else begin
      if (wr_rcr) len_q <= pwdata[15:0];
      porf_q <= porf_q & ~(wr_rsr & pwdata[0]);
      wdgf_q <= wdg_evt | (wdgf_q & ~(wr_rsr & pwdata[1]));
      swf_q  <= sw_evt  | (swf_q  & ~(wr_rsr & pwdata[2]));
      wcnt_q <= wdg_evt ? wcnt_sat_inc(wcnt_base) : wcnt_base;
    end
  end

`ifdef RSTC_WDG_IRQ_EN
  logic wr_isr;
  logic wint_q, wif_q, wie_q, irq_q;
  logic wif_d, wie_d;

  assign wr_isr = wr & (paddr[3:2] == 2'b10);

  always_comb begin
    wif_d = wif_q;
    if (wr_isr & pwdata[0]) wif_d = 1'b0;
    if (trig)               wif_d = 1'b0;
    if (wdg_int & ~wint_q)  wif_d = 1'b1;
    wie_d = wr_isr ? pwdata[1] : wie_q;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wint_q <= 1'b0;
      wif_q  <= 1'b0;
      wie_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      wint_q <= wdg_int;
      wif_q  <= wif_d;
      wie_q  <= wie_d;
      irq_q  <= wif_d & wie_d;
    end
  end

  assign irq       = irq_q;
  assign isr_rdata = {30'd0, wie_q, wif_q};

  logic unused_ok;
  assign unused_ok = ^{penable, paddr[31:4], paddr[1:0]};
`else
  assign irq       = 1'b0;
  assign isr_rdata = 32'd0;

  logic unused_ok;
  assign unused_ok = ^{penable, paddr[31:4], paddr[1:0], wdg_int};
`endif

  always_comb begin
    rdata = 32'd0;
    if (rd) begin
      case (paddr[3:2])
        2'b00:   rdata = {16'd0, len_q};
        2'b01:   rdata = {24'd0, wcnt_q, 1'b0, swf_q, wdgf_q, porf_q};
        2'b10:   rdata = isr_rdata;
        default: rdata = 32'd0;
      endcase
    end
  end

  assign prdata   = presetn ? rdata : 32'd0;
  assign sys_rstn = sys_rstn_q;

endmodule

// File: tb/tb_apb_rst_ctrl.sv
// Directed bench for apb_rst_ctrl: POR, watchdog/SW resets, flags, boundaries, IRQ option.
module tb_apb_rst_ctrl;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [31:0] paddr = 32'd0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic        wdg_rst = 1'b0;
  logic        wdg_int = 1'b0;
  logic        sys_rstn;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  apb_rst_ctrl dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
    .wdg_rst(wdg_rst), .wdg_int(wdg_int), .sys_rstn(sys_rstn), .irq(irq)
  );

  always #5 pclk = ~pclk;

  // Write is applied at the posedge; task returns 1 ns after that edge.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    psel = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b0; paddr = a;
    #1 d = prdata;
    psel = 1'b0;
  endtask

  task automatic wdg_pulse();
    @(negedge pclk);
    wdg_rst = 1'b1;
    @(posedge pclk); #1;
    wdg_rst = 1'b0;
  endtask

  // Counts rising clock edges until sys_rstn is seen high; bounded at 1000.
  task automatic measure_low(output int n);
    n = 0;
    while (n < 1000) begin
      @(posedge pclk); #1;
      n++;
      if (sys_rstn === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int n;
    presetn = 1'b0;
    #1;
    n_tests++;
    if (sys_rstn !== 1'b0) begin n_fail++; $display("FAIL por_sysrstn got=%b exp=0", sys_rstn); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL por_irq got=%b exp=0", irq); end
    apb_read(32'h4, d);
    n_tests++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL por_prdata got=%h exp=0", d); end
    #2000;
    @(negedge pclk);
    presetn = 1'b1;
    measure_low(n);
    n_tests++;
    if (n !== 202) begin n_fail++; $display("FAIL por_len got=%0d exp=202", n); end
    apb_read(32'h4, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL por_rsr got=%h exp=1", d); end
    apb_read(32'h0, d);
    n_tests++;
    if (d !== 32'd200) begin n_fail++; $display("FAIL por_rcr got=%h exp=c8", d); end
  endtask

  task automatic test_wdg();
    logic [31:0] d;
    int n;
    wdg_pulse();
    n_tests++;
    if (sys_rstn !== 1'b0) begin n_fail++; $display("FAIL wdg_assert got=%b exp=0", sys_rstn); end
    measure_low(n);
    n_tests++;
    if (n !== 202) begin n_fail++; $display("FAIL wdg_len got=%0d exp=202", n); end
    apb_read(32'h4, d);
    n_tests++;
    if (d !== 32'h13) begin n_fail++; $display("FAIL wdg_rsr got=%h exp=13", d); end
  endtask

  task automatic test_sw();
    logic [31:0] d;
    int n;
    apb_write(32'h0, 32'hA5C3_0004);
    measure_low(n);
    n_tests++;
    if (n !== 6) begin n_fail++; $display("FAIL sw_len got=%0d exp=6", n); end
    apb_read(32'h4, d);
    n_tests++;
    if (d !== 32'h17) begin n_fail++; $display("FAIL sw_rsr got=%h exp=17", d); end
    apb_read(32'h0, d);
    n_tests++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL sw_rcr got=%h exp=4", d); end
    apb_write(32'h0, 32'h1234_0004);
    n = 0;
    repeat (5) begin
      @(posedge pclk); #1;
      if (sys_rstn !== 1'b1) n++;
    end
    n_tests++;
    if (n !== 0) begin n_fail++; $display("FAIL badkey_low got=%0d exp=0", n); end
    apb_read(32'h4, d);
    n_tests++;
    if (d !== 32'h17) begin n_fail++; $display("FAIL badkey_rsr got=%h exp=17", d); end
  endtask

  task automatic test_both_and_sat();
    logic [31:0] d;
    int n;
    int bad;
    apb_write(32'h4, 32'hF);
    apb_read(32'h4, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL clr_all got=%h exp=0", d); end
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hA5C3_00C8; wdg_rst = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; pwrite = 1'b0; wdg_rst = 1'b0;
    measure_low(n);
    n_tests++;
    if (n !== 202) begin n_fail++; $display("FAIL both_len got=%0d exp=202", n); end
    apb_read(32'h4, d);
    n_tests++;
    if (d !== 32'h16) begin n_fail++; $display("FAIL both_rsr got=%h exp=16", d); end
    apb_write(32'h0, 32'h1);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      wdg_pulse();
      measure_low(n);
      if (n !== 3) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL len1_pulses got=%0d bad exp=0", bad); end
    apb_read(32'h4, d);
    n_tests++;
    if (d !== 32'hF6) begin n_fail++; $display("FAIL wcnt_sat got=%h exp=f6", d); end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    int n;
    apb_write(32'h4, 32'h7);
    apb_read(32'h4, d);
    n_tests++;
    if (d !== 32'hF0) begin n_fail++; $display("FAIL w1c_flags got=%h exp=f0", d); end
    apb_write(32'h4, 32'h8);
    apb_read(32'h4, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_wcnt got=%h exp=0", d); end
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h2; wdg_rst = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; pwrite = 1'b0; wdg_rst = 1'b0;
    measure_low(n);
    n_tests++;
    if (n !== 3) begin n_fail++; $display("FAIL w1c_evt_len got=%0d exp=3", n); end
    apb_read(32'h4, d);
    n_tests++;
    if (d !== 32'h12) begin n_fail++; $display("FAIL w1c_evt_wins got=%h exp=12", d); end
  endtask

  task automatic test_ignore_in_seq();
    logic [31:0] d;
    int n;
    apb_write(32'h4, 32'hF);
    apb_write(32'h0, 32'hA);
    wdg_pulse();
    apb_write(32'h0, 32'hA5C3_0005);
    wdg_pulse();
    measure_low(n);
    n_tests++;
    if (n !== 10) begin n_fail++; $display("FAIL ignore_len got=%0d exp=10", n); end
    apb_read(32'h4, d);
    n_tests++;
    if (d !== 32'h12) begin n_fail++; $display("FAIL ignore_rsr got=%h exp=12", d); end
    apb_read(32'h0, d);
    n_tests++;
    if (d !== 32'h5) begin n_fail++; $display("FAIL hold_len_wr got=%h exp=5", d); end
    wdg_pulse();
    measure_low(n);
    n_tests++;
    if (n !== 7) begin n_fail++; $display("FAIL next_len got=%0d exp=7", n); end
  endtask

  task automatic test_por_mid();
    logic [31:0] d;
    int n;
    wdg_pulse();
    repeat (2) @(negedge pclk);
    presetn = 1'b0;
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    measure_low(n);
    n_tests++;
    if (n !== 202) begin n_fail++; $display("FAIL por_mid_len got=%0d exp=202", n); end
    apb_read(32'h4, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL por_mid_rsr got=%h exp=1", d); end
    apb_read(32'h0, d);
    n_tests++;
    if (d !== 32'd200) begin n_fail++; $display("FAIL por_mid_rcr got=%h exp=c8", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
`ifdef RSTC_WDG_IRQ_EN
    apb_write(32'h8, 32'h2);
    apb_read(32'h8, d);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL isr_wie got=%h exp=2", d); end
    @(negedge pclk);
    wdg_int = 1'b1;
    @(posedge pclk); #1;
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got=%b exp=1", irq); end
    apb_read(32'h8, d);
    n_tests++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL isr_wif got=%h exp=3", d); end
    apb_write(32'h8, 32'h3);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clr got=%b exp=0", irq); end
    apb_read(32'h8, d);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL isr_after_clr got=%h exp=2", d); end
    wdg_int = 1'b0;
`else
    int hi;
    apb_write(32'h8, 32'h3);
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      wdg_int = ~wdg_int;
      @(posedge pclk); #1;
      if (irq !== 1'b0) hi++;
    end
    wdg_int = 1'b0;
    n_tests++;
    if (hi !== 0) begin n_fail++; $display("FAIL irq_tied got=%0d high exp=0", hi); end
    apb_read(32'h8, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL isr_read got=%h exp=0", d); end
`endif
  endtask

  initial begin
    test_reset();
    test_wdg();
    test_sw();
    test_both_and_sat();
    test_w1c();
    test_ignore_in_seq();
    test_por_mid();
    test_irq();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
